// File: rtl/daq_tdc_multi.sv
// Multi-channel time-to-digital converter with per-channel delays, masked
// start/stop coincidence and a show-ahead event FIFO.
module daq_tdc_multi #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 16,
  parameter int DLY_W   = 16,
  parameter int FIFO_AW = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [N_CH-1:0]         hit,
  input  logic [N_CH*DLY_W-1:0]   dly_size,
  input  logic [N_CH-1:0]         start_mask,
  input  logic [N_CH-1:0]         start_veto,
  input  logic [N_CH-1:0]         stop_mask,
  input  logic [CNT_W-1:0]        timeout,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [CNT_W-1:0]        evt_time,
  output logic [N_CH-1:0]         evt_pattern,
  output logic                    evt_timeout,
  output logic [FIFO_AW:0]        fifo_count,
  output logic [15:0]             overflow_cnt
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam int EW    = CNT_W + N_CH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PUSH = 2'd2
  } state_t;

  logic [N_CH-1:0]  sync1_r;
  logic [N_CH-1:0]  sync2_r;
  logic [N_CH-1:0]  sync3_r;
  logic [N_CH-1:0]  edge_r;
  logic [DLY_W-1:0] dcnt_r [N_CH];
  logic [N_CH-1:0]  busy_r;
  logic [N_CH-1:0]  d_s;
  logic             start_s;
  logic             stop_s;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] lat_time_r;
  logic [N_CH-1:0]  lat_pat_r;
  logic             lat_to_r;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             wr_s;
  logic             drop_s;
  logic [EW-1:0]    mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]   count_r;
  logic [15:0]        ovf_r;

  // Two-flop synchroniser followed by a registered rising-edge detector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
      sync3_r <= '0;
      edge_r  <= '0;
    end else begin
      sync1_r <= hit;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      edge_r  <= sync2_r & ~sync3_r;
    end
  end

  // Per-channel delay countdown; edges seen while busy are dead time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= '0;
      for (int i = 0; i < N_CH; i++) dcnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!enable) begin
          busy_r[i] <= 1'b0;
        end else if (!busy_r[i]) begin
          if (edge_r[i]) begin
            busy_r[i] <= 1'b1;
            dcnt_r[i] <= (dly_size[i*DLY_W +: DLY_W] == DLY_W'(0)) ?
                         DLY_W'(1) : dly_size[i*DLY_W +: DLY_W];
          end
        end else if (dcnt_r[i] == DLY_W'(1)) begin
          busy_r[i] <= 1'b0;
        end else begin
          dcnt_r[i] <= dcnt_r[i] - DLY_W'(1);
        end
      end
    end
  end

  // Delayed pulses and coincidence decode
  always_comb begin
    d_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      d_s[i] = busy_r[i] && (dcnt_r[i] == DLY_W'(1));
    end
    start_s = (start_mask != '0) && ((d_s & start_mask) == start_mask) &&
              ((d_s & start_veto) == '0);
    stop_s  = (stop_mask != '0) && ((d_s & stop_mask) == stop_mask);
  end

  // Measurement FSM: stop outranks timeout; starts outside IDLE are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= '0;
      lat_time_r <= '0;
      lat_pat_r  <= '0;
      lat_to_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (enable && start_s) begin
            cnt_r   <= CNT_W'(1);
            state_r <= S_RUN;
          end
        end
        S_RUN: begin
          if (!enable) begin
            state_r <= S_IDLE;
          end else if (stop_s) begin
            lat_time_r <= cnt_r;
            lat_pat_r  <= d_s;
            lat_to_r   <= 1'b0;
            state_r    <= S_PUSH;
          end else if ((timeout != CNT_W'(0)) && (cnt_r == timeout)) begin
            lat_time_r <= timeout;
            lat_pat_r  <= '0;
            lat_to_r   <= 1'b1;
            state_r    <= S_PUSH;
          end else if (cnt_r != {CNT_W{1'b1}}) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_PUSH: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO handshake: a full FIFO still accepts a push when the head leaves
  always_comb begin
    push_s = (state_r == S_PUSH) && enable;
    pop_s  = (count_r != (FIFO_AW+1)'(0)) && evt_ready;
    full_s = (count_r == (FIFO_AW+1)'(DEPTH));
    wr_s   = push_s && (!full_s || pop_s);
    drop_s = push_s && !wr_s;
  end

  // FIFO storage, pointers, occupancy and saturating drop counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      ovf_r    <= 16'd0;
    end else begin
      if (wr_s) begin
        mem_r[wr_ptr_r] <= {lat_time_r, lat_pat_r, lat_to_r};
        wr_ptr_r        <= wr_ptr_r + FIFO_AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
      end
      case ({wr_s, pop_s})
        2'b10:   count_r <= count_r + (FIFO_AW+1)'(1);
        2'b01:   count_r <= count_r - (FIFO_AW+1)'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s && (ovf_r != 16'hFFFF)) begin
        ovf_r <= ovf_r + 16'd1;
      end
    end
  end

  assign evt_valid    = (count_r != (FIFO_AW+1)'(0));
  assign {evt_time, evt_pattern, evt_timeout} = mem_r[rd_ptr_r];
  assign fifo_count   = count_r;
  assign overflow_cnt = ovf_r;

endmodule

// File: tb/tb_daq_tdc_multi.sv
// Self-checking bench for daq_tdc_multi: vector table of single measurements
// plus hand-built sequences for alignment, overflow, abort and reset.
module tb_daq_tdc_multi;

  localparam int N_CH = 4, CNT_W = 16, DLY_W = 16, FIFO_AW = 3;

  logic                  clk;
  logic                  rst;
  logic                  enable;
  logic [N_CH-1:0]       hit;
  logic [N_CH*DLY_W-1:0] dly_size;
  logic [N_CH-1:0]       start_mask, start_veto, stop_mask;
  logic [CNT_W-1:0]      timeout;
  logic                  evt_valid, evt_ready, evt_timeout;
  logic [CNT_W-1:0]      evt_time;
  logic [N_CH-1:0]       evt_pattern;
  logic [FIFO_AW:0]      fifo_count;
  logic [15:0]           overflow_cnt;

  daq_tdc_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .DLY_W(DLY_W), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .hit(hit), .dly_size(dly_size),
    .start_mask(start_mask), .start_veto(start_veto), .stop_mask(stop_mask),
    .timeout(timeout), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_time(evt_time), .evt_pattern(evt_pattern), .evt_timeout(evt_timeout),
    .fifo_count(fifo_count), .overflow_cnt(overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0] t;
    logic [N_CH-1:0]  p;
    logic             to;
  } evt_t;

  typedef struct {
    logic [N_CH-1:0]  sb;
    logic [N_CH-1:0]  pb;
    int               gap;
    logic [CNT_W-1:0] tmo;
    int               exp_cnt;
    evt_t             e;
  } vec_t;

  evt_t sbq[$];
  vec_t vecs[10];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic evt_t mk_evt(input int t, input logic [N_CH-1:0] p, input logic to);
    evt_t e;
    e.t = CNT_W'(t);
    e.p = p;
    e.to = to;
    return e;
  endfunction

  function automatic vec_t mk(input logic [N_CH-1:0] sb, input logic [N_CH-1:0] pb,
                              input int gap, input int tmo, input int exp_cnt,
                              input int t, input logic [N_CH-1:0] p, input logic to);
    vec_t v;
    v.sb = sb;
    v.pb = pb;
    v.gap = gap;
    v.tmo = CNT_W'(tmo);
    v.exp_cnt = exp_cnt;
    v.e = mk_evt(t, p, to);
    return v;
  endfunction

  // Compare the FIFO head against the oldest expected event
  task automatic check_head();
    evt_t e;
    if (sbq.size() == 0) begin
      chk("unexpected_event", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk("evt_valid", 32'(evt_valid), 32'd1);
      chk("evt_time", 32'(evt_time), 32'(e.t));
      chk("evt_pattern", 32'(evt_pattern), 32'(e.p));
      chk("evt_timeout", 32'(evt_timeout), 32'(e.to));
    end
  endtask

  // Start pulse on sb at c=0, stop pulse on pb at c=gap; optional 1-cycle ready at rdy_at
  task automatic drive_event(input logic [N_CH-1:0] sb, input logic [N_CH-1:0] pb,
                             input int gap, input int settle, input int rdy_at);
    for (int c = 0; c < gap + settle; c++) begin
      hit = ((c < 2) ? sb : 4'b0000) | ((c >= gap && c < gap + 2) ? pb : 4'b0000);
      if (c == rdy_at) begin
        evt_ready = 1'b1;
        check_head();
      end else begin
        evt_ready = 1'b0;
      end
      @(negedge clk);
    end
    hit = 4'b0000;
    evt_ready = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 200;
    evt_ready = 1'b1;
    while (sbq.size() > 0 && budget > 0) begin
      if (evt_valid) check_head();
      @(negedge clk);
      budget--;
    end
    evt_ready = 1'b0;
    chk("drain_left", 32'(sbq.size()), 32'd0);
    chk("drain_count", 32'(fifo_count), 32'd0);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_valid"}, 32'(evt_valid), 32'd0);
    chk({name, "_count"}, 32'(fifo_count), 32'd0);
    chk({name, "_time"}, 32'(evt_time), 32'd0);
    chk({name, "_pattern"}, 32'(evt_pattern), 32'd0);
    chk({name, "_to"}, 32'(evt_timeout), 32'd0);
    chk({name, "_ovf"}, 32'(overflow_cnt), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(4'b0011, 4'b1000, 40,   0, 1,  40, 4'b1000, 1'b0);
    vecs[1] = mk(4'b0011, 4'b1000,  7,   0, 1,   7, 4'b1000, 1'b0);
    vecs[2] = mk(4'b0011, 4'b1000,  3,   0, 1,   3, 4'b1000, 1'b0);
    vecs[3] = mk(4'b0011, 4'b0000,  5, 100, 1, 100, 4'b0000, 1'b1);
    vecs[4] = mk(4'b0011, 4'b1000, 20,  50, 1,  20, 4'b1000, 1'b0);
    vecs[5] = mk(4'b0011, 4'b1000, 30,  30, 1,  30, 4'b1000, 1'b0);
    vecs[6] = mk(4'b0011, 4'b1000, 60,  25, 1,  25, 4'b0000, 1'b1);
    vecs[7] = mk(4'b0011, 4'b1100, 15,   0, 1,  15, 4'b1100, 1'b0);
    vecs[8] = mk(4'b0111, 4'b1000, 20,   0, 0,   0, 4'b0000, 1'b0);
    vecs[9] = mk(4'b0001, 4'b1000, 20,   0, 0,   0, 4'b0000, 1'b0);

    rst = 1'b0; enable = 1'b0; hit = 4'b0000; evt_ready = 1'b0;
    dly_size = {4{16'd5}};
    start_mask = 4'b0011; start_veto = 4'b0100; stop_mask = 4'b1000;
    timeout = 16'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    enable = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      timeout = vecs[i].tmo;
      if (vecs[i].exp_cnt != 0) sbq.push_back(vecs[i].e);
      drive_event(vecs[i].sb, vecs[i].pb, vecs[i].gap,
                  ((int'(vecs[i].tmo) > vecs[i].gap) ? int'(vecs[i].tmo) - vecs[i].gap : 0) + 15, -1);
      chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].exp_cnt));
      drain();
    end
    timeout = 16'd0;

    // Zero delay behaves as one cycle
    dly_size = {4{16'd0}};
    sbq.push_back(mk_evt(9, 4'b1000, 1'b0));
    drive_event(4'b0011, 4'b1000, 9, 15, -1);
    chk("dly0_count", 32'(fifo_count), 32'd1);
    drain();

    // Different delays align ch0/ch1; ch1 re-hit while busy must be ignored
    dly_size = {4{16'd5}};
    dly_size[0 +: 16] = 16'd10;
    dly_size[16 +: 16] = 16'd6;
    sbq.push_back(mk_evt(25, 4'b1000, 1'b0));
    for (int c = 0; c < 50; c++) begin
      hit[0] = (c < 2);
      hit[1] = (c >= 4 && c < 6) || (c >= 7 && c < 9);
      hit[2] = 1'b0;
      hit[3] = (c >= 30 && c < 32);
      @(negedge clk);
    end
    hit = 4'b0000;
    chk("align_count", 32'(fifo_count), 32'd1);
    drain();
    dly_size = {4{16'd5}};

    // Fill, overflow, then a push coinciding with a pop while full
    for (int i = 0; i < 9; i++) begin
      if (i < 8) sbq.push_back(mk_evt(10 + 3 * i, 4'b1000, 1'b0));
      drive_event(4'b0011, 4'b1000, 10 + 3 * i, 15, -1);
      if (i == 7) begin
        chk("full_count", 32'(fifo_count), 32'd8);
        chk("full_ovf", 32'(overflow_cnt), 32'd0);
      end
    end
    chk("ovf_count", 32'(fifo_count), 32'd8);
    chk("ovf_cnt", 32'(overflow_cnt), 32'd1);
    sbq.push_back(mk_evt(50, 4'b1000, 1'b0));
    drive_event(4'b0011, 4'b1000, 50, 15, 59);
    chk("pushpop_count", 32'(fifo_count), 32'd8);
    chk("pushpop_ovf", 32'(overflow_cnt), 32'd1);
    drain();

    // Enable drop mid-run discards the measurement
    drive_event(4'b0011, 4'b0000, 5, 20, -1);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("abort_count", 32'(fifo_count), 32'd0);
    sbq.push_back(mk_evt(17, 4'b1000, 1'b0));
    drive_event(4'b0011, 4'b1000, 17, 15, -1);
    chk("after_abort_count", 32'(fifo_count), 32'd1);
    drain();

    // Asynchronous reset mid-run with a non-empty FIFO
    sbq.push_back(mk_evt(12, 4'b1000, 1'b0));
    drive_event(4'b0011, 4'b1000, 12, 15, -1);
    chk("prereset_count", 32'(fifo_count), 32'd1);
    drive_event(4'b0011, 4'b0000, 5, 20, -1);
    #3;
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    sbq.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sbq.push_back(mk_evt(22, 4'b1000, 1'b0));
    drive_event(4'b0011, 4'b1000, 22, 15, -1);
    chk("post_reset_count", 32'(fifo_count), 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/daq_tdc_multi.md
Name: daq_tdc_multi

Overview:
- Parametrised multi-channel successor to the single start/stop scintillator DAQ.
- Each of N_CH discriminated inputs is synchronised, edge-detected and delayed by a programmable per-channel amount.
- A masked coincidence with veto starts a time measurement, and a masked stop pattern or programmable timeout ends it.
- Each finished measurement is pushed as an event word into an on-chip FIFO, drained through a valid/ready interface.

Parameters:
N_CH, 4, number of input channels (2..16)
CNT_W, 16, width of time counter and timeout
DLY_W, 16, width of each per-channel delay value
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
enable  input  1  run enable; low aborts and blocks measurements
hit  input  N_CH  raw discriminator inputs, asynchronous
dly_size  input  N_CH*DLY_W  per-channel delay; channel i at bits [i*DLY_W +: DLY_W]
start_mask  input  N_CH  channels required high for start
start_veto  input  N_CH  channels that must be low for start
stop_mask  input  N_CH  channels required high for stop
timeout  input  CNT_W  fake-stop limit in cycles; 0 disables
evt_valid  output  1  FIFO head valid
evt_ready  input  1  consumer accepts head
evt_time  output  CNT_W  head: start-to-stop cycles
evt_pattern  output  N_CH  head: delayed-pulse vector at stop (0 on timeout)
evt_timeout  output  1  head: ended by timeout
fifo_count  output  FIFO_AW+1  FIFO occupancy
overflow_cnt  output  16  dropped events, saturating

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM IDLE, FIFO empty, delay units idle, counters 0. Config inputs are not latched and are sampled live.
- Input path, per channel:
  - 2-flop synchroniser, then rising-edge detect giving a 1-cycle edge pulse.
  - Total latency from the hit edge to the edge pulse is 3 clk.
- Delay unit, per channel:
  - When idle, an edge pulse loads dly_size (0 treated as 1) and enters BUSY.
  - In BUSY the counter decrements each cycle.
  - When counter==1, d[i] pulses high for exactly one cycle and the unit returns to idle.
  - Edge-to-d latency is dly_size cycles (1 if dly_size is 0).
  - Edges arriving while BUSY are ignored (dead time).
  - enable=0 forces all units idle.
- Start condition: start_mask!=0, (d & start_mask)==start_mask, and (d & start_veto)==0.
- Stop condition: stop_mask!=0 and (d & stop_mask)==stop_mask.
- FSM:
  - IDLE: if enable and start, load cnt=1 and go RUN. Stop is not evaluated in IDLE, so a stop coincident with start is ignored.
  - RUN:
    - If stop: latch time=cnt, pattern=d, to=0, go PUSH.
    - Else if timeout!=0 and cnt==timeout: latch time=timeout, pattern=0, to=1, go PUSH.
    - Else cnt <= cnt+1, saturating at all-ones.
    - Stop takes priority over timeout in the same cycle.
    - A start arriving in RUN is ignored.
  - PUSH: write the latched event to the FIFO, then go IDLE. A start in PUSH is ignored.
  - enable=0 in RUN or PUSH returns to IDLE with no event written. Overflow_cnt is unchanged.
- Time semantics: if start is seen at cycle t and stop at cycle t+k (k≥1), evt_time=k.
- FIFO:
  - Show-ahead: evt_* reflect the head whenever evt_valid=1, and evt_valid = (fifo_count!=0).
  - Pop occurs when evt_valid && evt_ready.
  - A push is accepted if not full, or if full with a pop in the same cycle. Otherwise the event is dropped and overflow_cnt increments, saturating at 0xFFFF.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo depth.
  - An event becomes visible the cycle after PUSH.

Test Plan:
- Single event: N_CH=4, dly_size all 5, start_mask=0011, veto=0100, stop_mask=1000, timeout=0. Hit ch0+ch1 at T, then ch3 at T+40 cycles. Required: one event with evt_time=40, evt_pattern=1000, evt_timeout=0, fifo_count=1.
- Veto: same as above but ch2 also hit with ch0+ch1. Required: no start; a later ch3 hit produces no event; fifo_count=0.
- Timeout: start as in the single-event case, timeout=100, no stop. Required: evt_time=100, evt_timeout=1, evt_pattern=0.
- Per-channel delay alignment: ch0 hit at T with dly=10, ch1 hit at T+4 with dly=6. Required: start occurs (coincident d); a ch1 re-hit during BUSY does not retrigger.
- FIFO full/overflow: FIFO_AW=3 with evt_ready=0. Required: 8 events give fifo_count=8 and the 9th gives overflow_cnt=1. A 10th event pushed while evt_ready=1 is accepted with fifo_count held at 8. Draining returns events in order with correct times.
- Abort and reset: enable drops mid-RUN, which requires no event and IDLE. rst low asynchronously mid-RUN with FIFO non-empty requires all outputs 0 immediately; after release the next valid start/stop measures correctly.
